// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//
// Purpose:
//   Shares the single register-file write port among NREQ writeback
//   producers (ALU, load unit, multi-cycle mul/div/FPU). Each producer uses
//   a valid/ready handshake. A round-robin arbiter picks at most one winner
//   per cycle. The winner's destination register and data are registered
//   onto the write port (rf_we / rf_waddr / rf_wdata) one cycle later.
//
// Parameters:
//   NREQ  number of writeback requesters (2..8)
//   XLEN  writeback data width
//
// Ports:
//   clk, rst_n     clock; synchronous active-low reset
//   req_valid      [NREQ]       per-requester writeback request
//   req_ready      [NREQ]       per-requester grant (combinational)
//   req_rd         [NREQ*5]     destination register, requester i at [5i+4:5i]
//   req_data       [NREQ*XLEN]  writeback data, requester i at [XLEN*i +: XLEN]
//   hold           suppresses all grants (e.g. debug owns the regfile)
//   rf_we          registered regfile write enable
//   rf_waddr       registered regfile write address
//   rf_wdata       registered regfile write data
//   wb_busy        some request is valid but not granted this cycle
//
// Optional feature (macro WB_SCOREBOARD_EN):
//   iss_valid, iss_rd    instruction issue with its destination register
//   rs1_addr, rs2_addr   source registers to look up
//   rs1_busy, rs2_busy   source register still has a write outstanding
//   busy_vec [32]        in-flight destination register bitmap
// ---------------------------------------------------------------------------
module wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*5-1:0]    req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  input  logic                 hold,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 wb_busy
`ifdef WB_SCOREBOARD_EN
  ,
  input  logic                 iss_valid,
  input  logic [4:0]           iss_rd,
  input  logic [4:0]           rs1_addr,
  input  logic [4:0]           rs2_addr,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic [31:0]          busy_vec
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);
  localparam logic [PW:0]   NREQ_W   = (PW+1)'(NREQ);

  // Arbitration results
  logic [NREQ-1:0] grant_s;
  logic            grant_any_s;
  logic [PW-1:0]   grant_idx_s;
  logic            arb_en_s;
  logic [4:0]      sel_rd_s;
  logic [XLEN-1:0] sel_data_s;

  // Registered state
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

  assign arb_en_s = rst_n & ~hold;

  // Round-robin search starting at rr_ptr_q; the candidate index is wrapped
  // by subtraction so non-power-of-two NREQ never lands on an unused slot.
  always_comb begin : arb_search
    logic [PW:0] cand_v;
    grant_s     = '0;
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    cand_v      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_v = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (cand_v >= NREQ_W) begin
        cand_v = cand_v - NREQ_W;
      end else begin
        cand_v = cand_v;
      end
      if (arb_en_s && !grant_any_s && req_valid[cand_v[PW-1:0]]) begin
        grant_any_s                  = 1'b1;
        grant_idx_s                  = cand_v[PW-1:0];
        grant_s[cand_v[PW-1:0]]      = 1'b1;
      end else begin
        grant_any_s = grant_any_s;
      end
    end
  end

  // One-hot mux of the winner's rd/data (AND-OR, grant is at most one-hot).
  always_comb begin : winner_mux
    sel_rd_s   = 5'd0;
    sel_data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_rd_s   = sel_rd_s   | (req_rd[5*i +: 5]        & {5{grant_s[i]}});
      sel_data_s = sel_data_s | (req_data[XLEN*i +: XLEN] & {XLEN{grant_s[i]}});
    end
  end

  assign req_ready = grant_s;
  assign wb_busy   = |(req_valid & ~grant_s);

  // Next-state for the write port and round-robin pointer. A grant with
  // rd=0 is consumed (pointer advances) but never raises the write enable.
  always_comb begin : next_state
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    rr_ptr_d   = rr_ptr_q;
    if (grant_any_s) begin
      rf_we_d    = (sel_rd_s != 5'd0);
      rf_waddr_d = sel_rd_s;
      rf_wdata_d = sel_data_s;
      if (grant_idx_s == LAST_IDX) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx_s + PW'(1);
      end
    end else begin
      rf_we_d = 1'b0;
    end
  end

  // Write-port and pointer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

`ifdef WB_SCOREBOARD_EN
  logic [31:0] busy_q, busy_d;
  logic [31:0] set_mask_s, clr_mask_s;

  // Set is applied after clear so a re-issue to a register that is being
  // committed in the same cycle keeps it busy (new producer outstanding).
  always_comb begin : sb_next
    set_mask_s = (iss_valid && (iss_rd != 5'd0)) ? (32'd1 << iss_rd) : 32'd0;
    clr_mask_s = rf_we_q ? (32'd1 << rf_waddr_q) : 32'd0;
    busy_d     = (busy_q & ~clr_mask_s) | set_mask_s;
    busy_d[0]  = 1'b0;
  end

  // In-flight destination bitmap register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 32'd0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Lookups read the registered bitmap only; a clear happening this cycle
  // is not bypassed.
  assign busy_vec = busy_q;
  assign rs1_busy = busy_q[rs1_addr];
  assign rs2_busy = busy_q[rs2_addr];
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
//
// Directed, table-driven bench for wb_arbiter (NREQ=3, XLEN=32). Inputs are
// driven on the falling edge; combinational outputs are checked 1 time unit
// later, registered outputs 1 time unit after the following rising edge.
// The WB_SCOREBOARD_EN section runs only when the macro is defined.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

  localparam int NREQ = 3;
  localparam int XLEN = 32;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*5-1:0]    req_rd;
  logic [NREQ*XLEN-1:0] req_data;
  logic                 hold;
  logic                 rf_we;
  logic [4:0]           rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic                 wb_busy;
`ifdef WB_SCOREBOARD_EN
  logic                 iss_valid;
  logic [4:0]           iss_rd;
  logic [4:0]           rs1_addr;
  logic [4:0]           rs2_addr;
  logic                 rs1_busy;
  logic                 rs2_busy;
  logic [31:0]          busy_vec;
`endif

  wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .hold      (hold),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .wb_busy   (wb_busy)
`ifdef WB_SCOREBOARD_EN
    ,
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .busy_vec  (busy_vec)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0]      valid;
    logic                 hold;
    logic [NREQ*5-1:0]    rd;
    logic [NREQ*XLEN-1:0] data;
    logic [NREQ-1:0]      exp_ready;
    logic                 exp_busy;
    logic                 exp_we;
    logic [4:0]           exp_waddr;
    logic [XLEN-1:0]      exp_wdata;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  // Requesters may not drop valid before acceptance.
  logic [NREQ-1:0] prev_pend = '0;
  always @(posedge clk) begin
    assert ((prev_pend & ~req_valid) == '0)
      else $error("valid dropped before acceptance");
    prev_pend <= req_valid & ~req_ready;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [NREQ-1:0] v, input logic h,
                     input logic [NREQ*5-1:0] rd, input logic [NREQ*XLEN-1:0] d,
                     input logic [NREQ-1:0] rdy, input logic bsy,
                     input logic we, input logic [4:0] wa, input logic [XLEN-1:0] wd);
    vec_t t;
    t.valid = v; t.hold = h; t.rd = rd; t.data = d;
    t.exp_ready = rdy; t.exp_busy = bsy;
    t.exp_we = we; t.exp_waddr = wa; t.exp_wdata = wd;
    vecs.push_back(t);
  endtask

  localparam logic [14:0] RD_ALL = {5'd3, 5'd2, 5'd1};
  localparam logic [95:0] D_ALL  = {32'hA2A2_A2A2, 32'hA1A1_A1A1, 32'hA0A0_A0A0};

  initial begin
    // ---------------- vector table (pointer starts at 0 after reset)
    add(3'b001, 1'b0, {5'd0, 5'd0, 5'd5}, {32'd0, 32'd0, 32'hDEAD_BEEF}, 3'b001, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    add(3'b100, 1'b0, {5'd3, 5'd0, 5'd0}, {32'h33, 32'd0, 32'd0},       3'b100, 1'b0, 1'b1, 5'd3, 32'h33);
    add(3'b000, 1'b0, 15'd0, 96'd0,                                    3'b000, 1'b0, 1'b0, 5'd3, 32'h33);
    // all three valid: fairness 0,1,2,0,1,2
    add(3'b111, 1'b0, RD_ALL, D_ALL, 3'b001, 1'b1, 1'b1, 5'd1, 32'hA0A0_A0A0);
    add(3'b111, 1'b0, RD_ALL, D_ALL, 3'b010, 1'b1, 1'b1, 5'd2, 32'hA1A1_A1A1);
    add(3'b111, 1'b0, RD_ALL, D_ALL, 3'b100, 1'b1, 1'b1, 5'd3, 32'hA2A2_A2A2);
    add(3'b111, 1'b0, RD_ALL, D_ALL, 3'b001, 1'b1, 1'b1, 5'd1, 32'hA0A0_A0A0);
    add(3'b111, 1'b0, RD_ALL, D_ALL, 3'b010, 1'b1, 1'b1, 5'd2, 32'hA1A1_A1A1);
    add(3'b111, 1'b0, RD_ALL, D_ALL, 3'b100, 1'b1, 1'b1, 5'd3, 32'hA2A2_A2A2);
    // drain the still-pending requesters 0 and 1
    add(3'b011, 1'b0, RD_ALL, D_ALL, 3'b001, 1'b1, 1'b1, 5'd1, 32'hA0A0_A0A0);
    add(3'b010, 1'b0, RD_ALL, D_ALL, 3'b010, 1'b0, 1'b1, 5'd2, 32'hA1A1_A1A1);
    // rd=0: granted from ptr=2 (wraps to req0), no write enable
    add(3'b001, 1'b0, {5'd0, 5'd0, 5'd0}, {32'd0, 32'd0, 32'h1234}, 3'b001, 1'b0, 1'b0, 5'd0, 32'h1234);
    // pointer advanced past req0 -> req1 wins
    add(3'b011, 1'b0, {5'd0, 5'd6, 5'd4}, {32'd0, 32'h66, 32'h44}, 3'b010, 1'b1, 1'b1, 5'd6, 32'h66);
    add(3'b001, 1'b0, {5'd0, 5'd6, 5'd4}, {32'd0, 32'h66, 32'h44}, 3'b001, 1'b0, 1'b1, 5'd4, 32'h44);
    // hold for three cycles with req1 pending, then release
    add(3'b010, 1'b1, {5'd0, 5'd9, 5'd0}, {32'd0, 32'h99, 32'd0}, 3'b000, 1'b1, 1'b0, 5'd4, 32'h44);
    add(3'b010, 1'b1, {5'd0, 5'd9, 5'd0}, {32'd0, 32'h99, 32'd0}, 3'b000, 1'b1, 1'b0, 5'd4, 32'h44);
    add(3'b010, 1'b1, {5'd0, 5'd9, 5'd0}, {32'd0, 32'h99, 32'd0}, 3'b000, 1'b1, 1'b0, 5'd4, 32'h44);
    add(3'b010, 1'b0, {5'd0, 5'd9, 5'd0}, {32'd0, 32'h99, 32'd0}, 3'b010, 1'b0, 1'b1, 5'd9, 32'h99);

    // ---------------- initial reset with the first request already presented
    rst_n     = 1'b0;
    hold      = 1'b0;
    req_valid = vecs[0].valid;
    req_rd    = vecs[0].rd;
    req_data  = vecs[0].data;
`ifdef WB_SCOREBOARD_EN
    iss_valid = 1'b0; iss_rd = 5'd0; rs1_addr = 5'd7; rs2_addr = 5'd0;
`endif
    @(posedge clk);
    @(negedge clk);
    #1;
    check("reset ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    check("reset we",    64'(rf_we),        64'd0);
    check("reset waddr", 64'(rf_waddr),     64'd0);
    check("reset wdata", 64'(rf_wdata),     64'd0);
    check("reset ptr",   64'(dut.rr_ptr_q), 64'd0);

    // ---------------- table-driven section
    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n     = 1'b1;
      req_valid = vecs[i].valid;
      hold      = vecs[i].hold;
      req_rd    = vecs[i].rd;
      req_data  = vecs[i].data;
      #1;
      check($sformatf("v%0d ready", i), 64'(req_ready), 64'(vecs[i].exp_ready));
      check($sformatf("v%0d busy", i),  64'(wb_busy),   64'(vecs[i].exp_busy));
      @(posedge clk); #1;
      check($sformatf("v%0d we", i),    64'(rf_we),     64'(vecs[i].exp_we));
      check($sformatf("v%0d waddr", i), 64'(rf_waddr),  64'(vecs[i].exp_waddr));
      check($sformatf("v%0d wdata", i), 64'(rf_wdata),  64'(vecs[i].exp_wdata));
    end

    // ---------------- reset while req2 valid and a write is registered
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 3'b100;
    req_rd    = {5'd8, 5'd0, 5'd0};
    req_data  = {32'h88, 32'd0, 32'd0};
    #1;
    check("midrst we before edge", 64'(rf_we), 64'd1);
    check("midrst ready", 64'(req_ready), 64'd0);
    check("midrst busy",  64'(wb_busy),   64'd1);
    @(posedge clk); #1;
    check("midrst we",    64'(rf_we),        64'd0);
    check("midrst waddr", 64'(rf_waddr),     64'd0);
    check("midrst wdata", 64'(rf_wdata),     64'd0);
    check("midrst ptr",   64'(dut.rr_ptr_q), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("postrst ready", 64'(req_ready), 64'b100);
    @(posedge clk); #1;
    check("postrst we",    64'(rf_we),    64'd1);
    check("postrst waddr", 64'(rf_waddr), 64'd8);
    check("postrst wdata", 64'(rf_wdata), 64'h88);
    check("postrst ptr",   64'(dut.rr_ptr_q), 64'd0);
    @(negedge clk);
    req_valid = 3'b000;
    @(posedge clk); #1;
    check("idle we", 64'(rf_we), 64'd0);

`ifdef WB_SCOREBOARD_EN
    // ---------------- in-flight destination scoreboard
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd7;
    @(posedge clk); #1;
    check("sb set bit7", 64'(busy_vec[7]), 64'd1);
    check("sb rs1_busy", 64'(rs1_busy),    64'd1);
    check("sb rs2_busy", 64'(rs2_busy),    64'd0);
    @(negedge clk);
    iss_valid = 1'b0;
    req_valid = 3'b001; req_rd = {5'd0, 5'd0, 5'd7}; req_data = {32'd0, 32'd0, 32'h77};
    @(posedge clk); #1;
    check("sb commit we", 64'(rf_we), 64'd1);
    check("sb no bypass", 64'(rs1_busy), 64'd1);
    @(negedge clk);
    req_valid = 3'b000;
    @(posedge clk); #1;
    check("sb cleared", 64'(busy_vec), 64'd0);
    check("sb rs1 clr", 64'(rs1_busy), 64'd0);
    @(negedge clk);
    req_valid = 3'b001;
    iss_valid = 1'b1; iss_rd = 5'd0;
    @(posedge clk); #1;
    check("sb rd0 ignored", 64'(busy_vec), 64'd0);
    @(negedge clk);
    req_valid = 3'b000;
    iss_valid = 1'b1; iss_rd = 5'd7;
    #1;
    check("sb same-cycle we", 64'(rf_we), 64'd1);
    @(posedge clk); #1;
    check("sb set wins", 64'(busy_vec), 64'h80);
    @(negedge clk);
    iss_valid = 1'b0;
    @(posedge clk); #1;
    check("sb stays", 64'(rs1_busy), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the single register-file write port among NREQ writeback producers: ALU, load unit, and multi-cycle mul/div/FPU.
- Each producer uses a valid/ready handshake. The block round-robin arbitrates and registers the winner onto the write port, driving write_enable, address3 and write_data.
- Sits between the execute/memory writeback sources and the regfile, and optionally tracks in-flight destination registers for hazard detection.

Parameters:
- NREQ, 3, number of writeback requesters (2..8).
- XLEN, 32, data width of each writeback.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  NREQ  per-requester writeback request.
- req_ready  output  NREQ  per-requester grant/accept, combinational.
- req_rd  input  NREQ*5  destination register per requester, packed with requester i at [5i+4:5i].
- req_data  input  NREQ*XLEN  writeback data per requester, packed.
- hold  input  1  when 1, no grants are issued (e.g. debug port owns the regfile).
- rf_we  output  1  regfile write enable, registered.
- rf_waddr  output  5  regfile write address, registered.
- rf_wdata  output  XLEN  regfile write data, registered.
- wb_busy  output  1  1 when any req_valid is high and not granted this cycle.

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - rf_we=0, rf_waddr=0, rf_wdata=0, rr_ptr=0.
  - req_ready is forced to 0 combinationally while rst_n=0. Requests presented during reset are not consumed and must stay asserted.
- Arbitration is combinational each cycle:
  - At most one grant.
  - Search starts at rr_ptr and wraps modulo NREQ. The first i with req_valid[i]=1 wins and gets req_ready[i]=1.
  - No grant when hold=1 or rst_n=0.
- Pointer update: on a grant to i, rr_ptr <= (i+1) mod NREQ. With no grant, rr_ptr holds. NREQ not a power of two must wrap correctly, e.g. NREQ=3: 2 -> 0.
- Handshake:
  - A transfer occurs when req_valid[i] & req_ready[i].
  - A requester must hold valid, rd and data stable until it is accepted.
  - Deasserting valid before acceptance is illegal (assertion in bench).
- Write latency: a grant in cycle N produces rf_we=1, rf_waddr=rd, rf_wdata=data in cycle N+1. The regfile commits at the end of N+1. Peak throughput is one write per cycle.
- rd=0:
  - The request is granted and consumed normally and the pointer advances.
  - rf_we stays 0 in the next cycle. rf_waddr and rf_wdata may update, but rf_we=0.
- No grant in a cycle means rf_we=0 next cycle. rf_waddr and rf_wdata hold their last values.
- The write port has no back-pressure: the regfile always accepts.
- wb_busy = |req_valid & ~granted, i.e. the pending-conflict indicator for pipeline stall logic.
- hold asserted mid-stream: a write already registered still appears on the port next cycle; no new grants while hold=1.
- Fairness: with all requesters continuously valid, each is granted exactly once every NREQ cycles.

Optional Feature:
- Macro WB_SCOREBOARD_EN.
- When defined, the following ports are added:
  - iss_valid input 1 and iss_rd input 5: an instruction issued with this destination.
  - rs1_addr input 5 and rs2_addr input 5.
  - rs1_busy output 1 and rs2_busy output 1.
  - busy_vec output 32.
- busy_vec behaviour:
  - On iss_valid with iss_rd!=0, busy_vec[iss_rd] <= 1.
  - On a cycle where rf_we=1, busy_vec[rf_waddr] <= 0.
  - Simultaneous set and clear of the same register: set wins, since the new producer is outstanding.
  - busy_vec[0] is constantly 0. Reset clears all bits.
- rs1_busy = busy_vec[rs1_addr] and rs2_busy = busy_vec[rs2_addr], combinational, with no bypass of the current-cycle clear.
- Without the macro, these ports and the state do not exist and the behaviour above is unchanged.

Test Plan:
- Reset, then a single request: req_valid=3'b001, rd=5, data=0xDEADBEEF → req_ready=001 same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; the cycle after, rf_we=0.
- All three valid for 6 cycles with rr_ptr=0 → grant order 0,1,2,0,1,2; wb_busy=1 every cycle; each data appears on the port one cycle after its grant.
- Request rd=0, data=0x1234 → granted, rr_ptr advances, rf_we stays 0.
- hold=1 for 3 cycles with req1 valid → req_ready=0 and rf_we=0 throughout, and req1 stays stable. Release hold → granted next cycle, write one cycle later.
- Reset asserted while req2 is valid and a write is registered → after the reset edge rf_we=0, rr_ptr=0, req_ready=0 during reset; req2 is granted in the first cycle after reset.
- WB_SCOREBOARD_EN: issue rd=7 → busy_vec[7]=1 and rs1_busy=1 for rs1_addr=7. Writeback of rd=7 → cleared the cycle after rf_we. Same-cycle issue rd=7 and commit rd=7 → bit stays 1.
